// File: rtl/riscv_mem_pkg.sv
// Shared memory-side constants for the RV32I core.
// Owner encoding tags which port a pending read response belongs to.
package riscv_mem_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;

   typedef logic [1:0] own_t;

   localparam own_t OWN_NONE  = 2'b00;
   localparam own_t OWN_FETCH = 2'b10;
   localparam own_t OWN_DATA  = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones.
// Async active-low clear.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (en && (q != {W{1'b1}}))
         q <= q + W'(1);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between fetch and load/store.
// Data wins by default; a starvation counter forces fetch through.
module mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int DATA_W     = MEM_DATA_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       perf_if_stall
);

   logic [3:0] starve_q;
   own_t       own_q;
   logic       flush_q;
   logic       fetch_win;

   always_comb begin
      fetch_win = if_req && (starve_q == 4'(STARVE_MAX));
      d_gnt     = d_req & ~fetch_win;
      if_gnt    = if_req & ~d_gnt;
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (1'b1)
         d_gnt: begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
         end
         if_gnt: mem_addr = if_addr;
         default: ;
      endcase
   end

   assign mem_en = if_gnt | d_gnt;
   assign mem_we = d_gnt & d_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
         own_q    <= OWN_NONE;
         flush_q  <= 1'b0;
      end else begin
         if (if_gnt || !if_req)
            starve_q <= '0;
         else if (d_gnt)
            starve_q <= starve_q + 4'd1;
         own_q   <= {if_gnt, d_gnt & ~d_we};
         flush_q <= if_flush;
      end
   end

   // Late flush also kills the response in its return cycle
   assign if_rvalid = |(own_q & OWN_FETCH) & ~flush_q & ~if_flush;
   assign d_rvalid  = |(own_q & OWN_DATA);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

   sat_counter #(.W(32)) u_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (if_req & ~if_gnt),
      .q     (perf_if_stall)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed stimulus with a response scoreboard for mem_arbiter.
// Expected read data is queued at grant time and popped on rvalid.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_flush, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
   logic [31:0] if_rdata, d_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] perf_if_stall;
   logic        sat_en;
   logic [3:0]  sat_q;

   logic [31:0] ram [0:255];
   logic [31:0] ifq[$];
   logic [31:0] dq[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_req        (if_req),
      .if_addr       (if_addr),
      .if_flush      (if_flush),
      .if_gnt        (if_gnt),
      .if_rvalid     (if_rvalid),
      .if_rdata      (if_rdata),
      .d_req         (d_req),
      .d_we          (d_we),
      .d_addr        (d_addr),
      .d_wdata       (d_wdata),
      .d_gnt         (d_gnt),
      .d_rvalid      (d_rvalid),
      .d_rdata       (d_rdata),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .perf_if_stall (perf_if_stall)
   );

   sat_counter #(.W(4)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (sat_en),
      .q     (sat_q)
   );

   // Write-first synchronous RAM
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr[9:2]] <= mem_wdata;
            mem_rdata          <= mem_wdata;
         end else begin
            mem_rdata <= ram[mem_addr[9:2]];
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] ex);
      n_tests++;
      if (act !== ex) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, ex);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && if_rvalid) begin
         if (ifq.size() == 0) check("if_unexp", 32'(if_rvalid), 32'd0);
         else check("if_rdata", if_rdata, ifq.pop_front());
      end
      if (rst_n && d_rvalid) begin
         if (dq.size() == 0) check("d_unexp", 32'(d_rvalid), 32'd0);
         else check("d_rdata", d_rdata, dq.pop_front());
      end
   end

   task automatic drv(input logic ir, input logic [31:0] ia,
                      input logic fl, input logic dr, input logic we,
                      input logic [31:0] da, input logic [31:0] wd);
      @(posedge clk);
      #1;
      if_req   = ir;
      if_addr  = ia;
      if_flush = fl;
      d_req    = dr;
      d_we     = we;
      d_addr   = da;
      d_wdata  = wd;
      #1;
   endtask

   task automatic idle();
      drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic gnt(input string nm, input logic ei, input logic ed);
      check({nm, "_if_gnt"}, 32'(if_gnt), 32'(ei));
      check({nm, "_d_gnt"}, 32'(d_gnt), 32'(ed));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n    = 1'b0;
      if_req   = 1'b0;
      if_addr  = '0;
      if_flush = 1'b0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      sat_en   = 1'b0;
      for (int i = 0; i < 256; i++) ram[i] = '0;
      ram[0] = 32'h13;
      ram[1] = 32'h93;
      ram[2] = 32'h113;

      repeat (2) @(posedge clk);
      #1;
      check("rst_perf", perf_if_stall, 32'd0);
      check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      rst_n = 1'b1;

      // fetch only, back to back
      drv(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      gnt("f0", 1'b1, 1'b0);
      check("f0_mem_addr", mem_addr, 32'd0);
      ifq.push_back(32'h13);
      drv(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      gnt("f1", 1'b1, 1'b0);
      check("f1_mem_addr", mem_addr, 32'd4);
      ifq.push_back(32'h93);
      drv(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      gnt("f2", 1'b1, 1'b0);
      ifq.push_back(32'h113);
      idle();
      gnt("idle", 1'b0, 1'b0);
      check("idle_mem_en", 32'(mem_en), 32'd0);
      check("idle_mem_addr", mem_addr, 32'd0);
      check("idle_mem_wdata", mem_wdata, 32'd0);

      // store then load same address
      drv(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
      gnt("st", 1'b0, 1'b1);
      check("st_mem_we", 32'(mem_we), 32'd1);
      check("st_mem_addr", mem_addr, 32'h100);
      check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      drv(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h100, 32'd0);
      gnt("ld", 1'b0, 1'b1);
      check("ld_mem_we", 32'(mem_we), 32'd0);
      dq.push_back(32'hDEADBEEF);
      idle();

      // flush in grant cycle; next fetch still granted and delivered
      drv(1'b1, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      gnt("fl_a", 1'b1, 1'b0);
      drv(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      gnt("fl_a2", 1'b1, 1'b0);
      ifq.push_back(32'h113);
      idle();
      // flush in the return cycle
      drv(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      gnt("fl_b", 1'b1, 1'b0);
      drv(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      drv(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      gnt("fl_b2", 1'b1, 1'b0);
      ifq.push_back(32'h13);
      idle();

      // contention with STARVE_MAX = 4
      do_reset();
      check("cont_perf0", perf_if_stall, 32'd0);
      for (int i = 0; i < 10; i++) begin
         drv(1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'(i));
         gnt($sformatf("cont%0d", i), (i == 4) || (i == 9),
             !((i == 4) || (i == 9)));
         if (if_gnt) ifq.push_back(32'h13);
      end
      idle();
      check("cont_perf", perf_if_stall, 32'd8);

      // reset while a load is in flight
      do_reset();
      drv(1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 32'h300, 32'd5);
      gnt("rr_st", 1'b0, 1'b1);
      drv(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h100, 32'd0);
      gnt("rr_ld", 1'b0, 1'b1);
      check("rr_perf1", perf_if_stall, 32'd1);
      rst_n = 1'b0;
      idle();
      idle();
      rst_n = 1'b1;
      check("rr_perf0", perf_if_stall, 32'd0);
      check("rr_d_rvalid", 32'(d_rvalid), 32'd0);
      idle();
      idle();

      // saturation of a narrow counter instance
      check("sat_q0", 32'(sat_q), 32'd0);
      sat_en = 1'b1;
      repeat (14) @(posedge clk);
      #1 check("sat_q14", 32'(sat_q), 32'd14);
      repeat (6) @(posedge clk);
      #1 check("sat_hold", 32'(sat_q), 32'd15);
      sat_en = 1'b0;

      repeat (3) idle();
      check("if_pending", 32'(ifq.size()), 32'd0);
      check("d_pending", 32'(dq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
